// File: rtl/divide_fix_arbiter.sv
// divide_fix_arbiter
//   Round-robin sharing of one pipelined fixed-point divider among N_REQ
//   requesters. A tag shift register matched to the divider latency routes
//   each quotient back to the requester that issued it.
//
//   Optional feature macro: DIV_ZERO_GUARD_EN
//     defined   : divisor-0 requests bypass the divider and respond with
//                 all-ones data and rsp_div_zero=1 at the normal latency.
//     undefined : every request goes to the divider; rsp_div_zero stays 0.
//
//   Ports
//     aclk, reset            clock, synchronous active-high reset
//     req_valid/req_ready    per-requester request handshake (ready is comb.)
//     req_dividend/divisor   packed per-requester operands
//     div_a_*/div_b_*        divider operand streams
//     div_result_*           divider quotient stream
//     rsp_valid/rsp_data     one-hot response strobe and shared quotient
//     rsp_div_zero           response produced by the zero guard
//     busy                   flush active or ops in flight
//     sync_err               sticky divider/tag mismatch
module divide_fix_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = 44
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*40-1:0]  req_dividend,
  input  logic [N_REQ*8-1:0]   req_divisor,
  output logic                 div_a_tvalid,
  output logic                 div_b_tvalid,
  output logic [39:0]          div_a_tdata,
  output logic [7:0]           div_b_tdata,
  input  logic                 div_result_tvalid,
  input  logic [47:0]          div_result_tdata,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [47:0]          rsp_data,
  output logic                 rsp_div_zero,
  output logic                 busy,
  output logic                 sync_err
);

  localparam int unsigned DVD_W = 40;
  localparam int unsigned DVS_W = 8;
  localparam int unsigned QUO_W = 48;
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY + 2);

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic [CNT_W-1:0]   w_flush_cnt_nxt;
  logic               w_run;

  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_gnt_found;
  logic               w_hs;
  logic               w_zero;

  logic [DVD_W-1:0]   w_dvd_arr [N_REQ];
  logic [DVS_W-1:0]   w_dvs_arr [N_REQ];
  logic [DVD_W-1:0]   w_dvd_sel;
  logic [DVS_W-1:0]   w_dvs_sel;

  logic               r_issue_v;
  logic               r_issue_z;
  logic [ID_W-1:0]    r_issue_id;
  logic               r_div_tvalid;
  logic [DVD_W-1:0]   r_div_a;
  logic [DVS_W-1:0]   r_div_b;

  logic [LATENCY-1:0] r_tag_v;
  logic [LATENCY-1:0] r_tag_z;
  logic [ID_W-1:0]    r_tag_id [LATENCY];
  logic               w_tail_v;
  logic               w_tail_z;
  logic [ID_W-1:0]    w_tail_id;

  logic [N_REQ-1:0]   r_rsp_valid;
  logic [QUO_W-1:0]   r_rsp_data;
  logic               r_rsp_div_zero;
  logic               r_sync_err;

  // Flush FSM state register
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= CNT_W'(LATENCY + 1);
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Flush window covers every divider result that could still be in flight
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_FLUSH: begin
        w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
        if (r_flush_cnt == CNT_W'(1)) w_state_nxt = ST_RUN;
      end
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_FLUSH;
    endcase
  end

  assign w_run = (r_state == ST_RUN);

  // Unpack per-requester operands
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_dvd_arr[g] = req_dividend[g*DVD_W +: DVD_W];
    assign w_dvs_arr[g] = req_divisor[g*DVS_W +: DVS_W];
  end

  // Round-robin search from r_ptr upward with wrap
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    req_ready   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = ID_W'((32'(r_ptr) + k) % N_REQ);
      if (!w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
    if (w_run && w_gnt_found) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_hs      = |(req_valid & req_ready);
  assign w_dvd_sel = w_dvd_arr[w_gnt_idx];
  assign w_dvs_sel = w_dvs_arr[w_gnt_idx];

`ifdef DIV_ZERO_GUARD_EN
  assign w_zero = (w_dvs_sel == '0);
`else
  assign w_zero = 1'b0;
`endif

  // Issue register and round-robin pointer
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_issue_v    <= 1'b0;
      r_issue_z    <= 1'b0;
      r_issue_id   <= '0;
      r_div_tvalid <= 1'b0;
      r_div_a      <= '0;
      r_div_b      <= '0;
    end else begin
      r_issue_v    <= w_hs;
      r_div_tvalid <= w_hs & ~w_zero;
      if (w_hs) begin
        r_div_a    <= w_dvd_sel;
        r_div_b    <= w_dvs_sel;
        r_issue_id <= w_gnt_idx;
        r_issue_z  <= w_zero;
        r_ptr      <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
      end
    end
  end

  // Tag pipeline: stage 0 follows the issue register, tail lines up with the result
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_tag_v <= '0;
      r_tag_z <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v[0]  <= r_issue_v;
      r_tag_z[0]  <= r_issue_z;
      r_tag_id[0] <= r_issue_id;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_z[i]  <= r_tag_z[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign w_tail_v  = r_tag_v[LATENCY-1];
  assign w_tail_z  = r_tag_z[LATENCY-1];
  assign w_tail_id = r_tag_id[LATENCY-1];

  // Response stage; divider output is ignored entirely while flushing
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_rsp_div_zero <= 1'b0;
      r_sync_err     <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_run) begin
        if (w_tail_v) begin
          r_rsp_valid    <= N_REQ'(1) << w_tail_id;
          r_rsp_data     <= w_tail_z ? '1 : div_result_tdata;
          r_rsp_div_zero <= w_tail_z;
        end
        // Unmatched results are dropped; missing ones still respond with sampled data
        if (div_result_tvalid != (w_tail_v & ~w_tail_z)) r_sync_err <= 1'b1;
      end
    end
  end

  assign div_a_tvalid = r_div_tvalid;
  assign div_b_tvalid = r_div_tvalid;
  assign div_a_tdata  = r_div_a;
  assign div_b_tdata  = r_div_b;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_div_zero = r_rsp_div_zero;
  assign sync_err     = r_sync_err;
  assign busy         = (r_state == ST_FLUSH) | r_issue_v | (|r_tag_v);

endmodule

// File: tb/tb_divide_fix_arbiter.sv
// Directed bench for divide_fix_arbiter (N_REQ=4, LATENCY=44) with a
// pipelined divider stand-in that can drop one chosen result.
module tb_divide_fix_arbiter;

  localparam int N   = 4;
  localparam int LAT = 44;

  logic          aclk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*40-1:0] req_dividend;
  logic [N*8-1:0]  req_divisor;
  logic          div_a_tvalid, div_b_tvalid;
  logic [39:0]   div_a_tdata;
  logic [7:0]    div_b_tdata;
  logic          div_result_tvalid;
  logic [47:0]   div_result_tdata;
  logic [N-1:0]  rsp_valid;
  logic [47:0]   rsp_data;
  logic          rsp_div_zero;
  logic          busy;
  logic          sync_err;

  logic [39:0] tb_dvd [N];
  logic [7:0]  tb_dvs [N];
  logic [47:0] tb_q   [N];
  logic        tb_z   [N];

  assign req_dividend = {tb_dvd[3], tb_dvd[2], tb_dvd[1], tb_dvd[0]};
  assign req_divisor  = {tb_dvs[3], tb_dvs[2], tb_dvs[1], tb_dvs[0]};

  divide_fix_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
    .aclk              (aclk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_dividend      (req_dividend),
    .req_divisor       (req_divisor),
    .div_a_tvalid      (div_a_tvalid),
    .div_b_tvalid      (div_b_tvalid),
    .div_a_tdata       (div_a_tdata),
    .div_b_tdata       (div_b_tdata),
    .div_result_tvalid (div_result_tvalid),
    .div_result_tdata  (div_result_tdata),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_div_zero      (rsp_div_zero),
    .busy              (busy),
    .sync_err          (sync_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Divider stand-in: fixed latency, never reset, optional single drop
  logic [LAT-1:0] m_v    = '0;
  logic [LAT-1:0] m_drop = '0;
  logic [47:0]    m_q [LAT];
  logic           drop_arm;

  always @(posedge aclk) begin
    m_v    <= {m_v[LAT-2:0], div_a_tvalid};
    m_drop <= {m_drop[LAT-2:0], drop_arm & div_a_tvalid};
    m_q[0] <= (div_b_tdata == 8'd0) ? 48'hABC : 48'(div_a_tdata / 40'(div_b_tdata));
    for (int k = 1; k < LAT; k++) m_q[k] <= m_q[k-1];
    if (div_a_tvalid) drop_arm = 1'b0;
  end

  assign div_result_tvalid = m_v[LAT-1] & ~m_drop[LAT-1];
  assign div_result_tdata  = div_result_tvalid ? m_q[LAT-1] : 48'h0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          idx;
    logic [47:0] data;
    logic        z;
  } exp_t;

  exp_t exp_q[$];

  // Response scoreboard, sampled on the falling edge
  always @(negedge aclk) begin
    cyc++;
    if (!reset) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("rsp_cycle", 64'(cyc), 64'(e.due));
          check_eq("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
          check_eq("rsp_data",  64'(rsp_data),  64'(e.data));
          check_eq("rsp_zero",  64'(rsp_div_zero), 64'(e.z));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rsp_missing", 64'(rsp_valid), 64'(1) << e.idx);
      end
    end
  end

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic push_exp(input int gi);
    exp_t e;
    e.due  = cyc + LAT + 2;
    e.idx  = gi;
    e.data = tb_q[gi];
    e.z    = tb_z[gi];
    exp_q.push_back(e);
  endtask

  // One cycle of requests; gi is the requester expected to win (-1 = none)
  task automatic cyc_req(input logic [N-1:0] v, input int gi);
    step();
    req_valid = v;
    #1;
    check_eq("req_ready", 64'(req_ready), (gi < 0) ? 64'd0 : (64'(1) << gi));
    if (gi >= 0) push_exp(gi);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Pulse reset, hold v through the flush window, expect gi as first grant
  task automatic do_reset_flush(input logic [N-1:0] v, input int gi);
    step();
    reset     = 1'b1;
    req_valid = '0;
    exp_q.delete();
    step();
    reset     = 1'b0;
    req_valid = v;
    for (int k = 0; k < LAT + 1; k++) begin
      #1;
      check_eq("flush_ready", 64'(req_ready), 64'd0);
      check_eq("flush_busy",  64'(busy), 64'd1);
      check_eq("flush_err",   64'(sync_err), 64'd0);
      step();
    end
    #1;
    check_eq("first_grant", 64'(req_ready), 64'(1) << gi);
    push_exp(gi);
    step();
    req_valid = '0;
    check_eq("first_issue_v", 64'(div_a_tvalid), 64'd1);
    check_eq("first_issue_a", 64'(div_a_tdata), 64'(tb_dvd[gi]));
  endtask

  task automatic load_table();
    tb_dvd[0] = 40'd1000; tb_dvs[0] = 8'd2; tb_q[0] = 48'd500;
    tb_dvd[1] = 40'd2000; tb_dvs[1] = 8'd3; tb_q[1] = 48'd666;
    tb_dvd[2] = 40'd3000; tb_dvs[2] = 8'd4; tb_q[2] = 48'd750;
    tb_dvd[3] = 40'd4000; tb_dvs[3] = 8'd5; tb_q[3] = 48'd800;
  endtask

  int ord_a [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
  int ord_b [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int d;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    drop_arm  = 1'b0;
    for (int i = 0; i < N; i++) begin
      tb_dvd[i] = '0; tb_dvs[i] = '0; tb_q[i] = '0; tb_z[i] = 1'b0;
    end
    step();
    step();

    // Reset values
    check_eq("rst_ready",   64'(req_ready), 64'd0);
    check_eq("rst_a_valid", 64'(div_a_tvalid), 64'd0);
    check_eq("rst_b_valid", 64'(div_b_tvalid), 64'd0);
    check_eq("rst_a_data",  64'(div_a_tdata), 64'd0);
    check_eq("rst_b_data",  64'(div_b_tdata), 64'd0);
    check_eq("rst_rsp_v",   64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_d",   64'(rsp_data), 64'd0);
    check_eq("rst_rsp_z",   64'(rsp_div_zero), 64'd0);
    check_eq("rst_err",     64'(sync_err), 64'd0);
    check_eq("rst_busy",    64'(busy), 64'd1);

    // Flush window after reset, then first grant to requester 0
    tb_dvd[0] = 40'd500; tb_dvs[0] = 8'd4; tb_q[0] = 48'd125;
    do_reset_flush(4'b0001, 0);
    drain();
    step();
    check_eq("idle_busy", 64'(busy), 64'd0);

    // Single request: requester 2, 1000/10 (pointer now 1)
    tb_dvd[2] = 40'd1000; tb_dvs[2] = 8'd10; tb_q[2] = 48'd100;
    cyc_req(4'b0100, 2);
    step();
    req_valid = '0;
    check_eq("single_a_v", 64'(div_a_tvalid), 64'd1);
    check_eq("single_b_v", 64'(div_b_tvalid), 64'd1);
    check_eq("single_a",   64'(div_a_tdata), 64'd1000);
    check_eq("single_b",   64'(div_b_tdata), 64'd10);
    step();
    check_eq("single_pulse", 64'(div_a_tvalid), 64'd0);
    check_eq("single_hold",  64'(div_a_tdata), 64'd1000);
    drain();
    check_eq("single_err", 64'(sync_err), 64'd0);

    // All requesters continuously valid (pointer now 3)
    load_table();
    for (int k = 0; k < 8; k++) cyc_req(4'b1111, ord_a[k]);
    step();
    req_valid = '0;
    drain();

    // Single requester held valid is granted every cycle (pointer now 3)
    tb_dvd[1] = 40'd77; tb_dvs[1] = 8'd7; tb_q[1] = 48'd11;
    for (int k = 0; k < 4; k++) cyc_req(4'b0010, 1);
    step();
    req_valid = '0;
    drain();
    check_eq("stream_err", 64'(sync_err), 64'd0);

    // Dropped divider result (pointer now 2): response still fires with sampled data 0
    tb_dvd[0] = 40'd90; tb_dvs[0] = 8'd9; tb_q[0] = 48'd0;
    drop_arm = 1'b1;
    cyc_req(4'b0001, 0);
    d = cyc;
    step();
    req_valid = '0;
    while (cyc < d + LAT + 1) step();
    check_eq("drop_err_before", 64'(sync_err), 64'd0);
    step();
    check_eq("drop_err_set", 64'(sync_err), 64'd1);
    tb_dvd[3] = 40'd84; tb_dvs[3] = 8'd4; tb_q[3] = 48'd21;
    cyc_req(4'b1000, 3);
    step();
    req_valid = '0;
    drain();
    check_eq("drop_err_sticky", 64'(sync_err), 64'd1);

    // Reset with 8 ops in flight; stale results land inside the flush window
    load_table();
    for (int k = 0; k < 8; k++) cyc_req(4'b1111, ord_b[k]);
    step();
    req_valid = '0;
    step();
    do_reset_flush(4'b1111, 0);
    drain();
    check_eq("reset_err", 64'(sync_err), 64'd0);

    // Divisor-0 request from requester 1 between two normal ones (pointer now 1)
    tb_dvd[0] = 40'd50;  tb_dvs[0] = 8'd5; tb_q[0] = 48'd10;
    tb_dvd[1] = 40'd123; tb_dvs[1] = 8'd0;
    tb_dvd[2] = 40'd60;  tb_dvs[2] = 8'd3; tb_q[2] = 48'd20;
`ifdef DIV_ZERO_GUARD_EN
    tb_q[1] = 48'hFFFF_FFFF_FFFF; tb_z[1] = 1'b1;
`else
    tb_q[1] = 48'hABC;            tb_z[1] = 1'b0;
`endif
    cyc_req(4'b0001, 0);
    cyc_req(4'b0010, 1);
    check_eq("zero_prev_issue", 64'(div_a_tvalid), 64'd1);
    cyc_req(4'b0100, 2);
`ifdef DIV_ZERO_GUARD_EN
    check_eq("zero_no_issue", 64'(div_a_tvalid), 64'd0);
`else
    check_eq("zero_issued", 64'(div_a_tvalid), 64'd1);
`endif
    step();
    req_valid = '0;
    check_eq("zero_next_issue", 64'(div_a_tvalid), 64'd1);
    check_eq("zero_next_a",     64'(div_a_tdata), 64'd60);
    drain();
    check_eq("zero_err", 64'(sync_err), 64'd0);
    step();
    check_eq("end_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divide_fix_arbiter.md
# divide_fix_arbiter

Shares one pipelined fixed-point divider (40-bit dividend, 8-bit divisor, 48-bit quotient, fixed latency, no backpressure) between N_REQ requesters. Requests are granted round-robin at one issue per cycle. Each request's requester ID rides a tag shift register matched to the divider latency, so each quotient returns to the requester that issued it. The block sits between the per-channel scaling engines and the divider wrapper core and replaces per-channel divider instances.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- LATENCY, 44, divider cycles from input tvalid to m_axis tvalid (≥1)

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant, one-hot or zero
- req_dividend  in  N_REQ*40  packed dividends, requester i at [40i+39:40i]
- req_divisor  in  N_REQ*8  packed divisors, requester i at [8i+7:8i]
- div_a_tvalid / div_b_tvalid  out  1 each  divider input valids, always equal
- div_a_tdata  out  40  dividend to divider
- div_b_tdata  out  8  divisor to divider
- div_result_tvalid  in  1  divider output valid
- div_result_tdata  in  48  divider quotient
- rsp_valid  out  N_REQ  one-hot response strobe
- rsp_data  out  48  quotient, shared by all requesters
- rsp_div_zero  out  1  response came from the zero guard
- busy  out  1  ops in flight or reset flush active
- sync_err  out  1  sticky divider/tag mismatch flag

## Operation
- Arbiter: round-robin pointer `ptr`, reset value 0.
  - Grant goes to the first i with req_valid[i]=1, searching from ptr upward with wrap.
  - req_ready is combinational from req_valid and ptr.
  - Handshake = req_valid[i] & req_ready[i].
  - After a handshake, ptr = granted index + 1 mod N_REQ. With no handshake, ptr holds.
- Issue register: on handshake, latch dividend, divisor and ID. div_*_tvalid goes high the next cycle for exactly one cycle. With no handshake, tvalid is 0 and the data registers hold their value.
- Tag pipeline: LATENCY stages of {v, id[clog2(N_REQ)-1:0], z}, shifted every cycle. Stage 0 is loaded together with the issue register output.
- Response stage, registered, evaluated when the tag tail is valid:
  - rsp_valid[id]=1.
  - rsp_data = div_result_tdata when z=0; rsp_data = 48'hFFFF_FFFF_FFFF when z=1.
  - rsp_div_zero = z.
  - When the tail is invalid: rsp_valid=0, and rsp_data holds its last value.
- Mismatch: if div_result_tvalid differs from the expected divider valid at the tail (v & ~z), set sync_err.
  - A divider result with no matching tag is dropped.
  - A missing result still yields rsp_valid, with rsp_data = the div_result_tdata sampled that cycle.
- Reset flush FSM:
  - States: FLUSH → RUN. FLUSH is entered on reset.
  - A counter loads LATENCY+1 and decrements each cycle. FLUSH → RUN when it reaches 0.
  - In FLUSH: req_ready=0, div_result_tvalid is ignored (no sync_err, no rsp), busy=1.
- Reset values: req_ready=0, div_*_tvalid=0, div data=0, all tags invalid, rsp_valid=0, rsp_data=0, rsp_div_zero=0, sync_err=0, busy=1 (FLUSH).
- sync_err clears only on reset.
- busy = FLUSH | issue valid | any tag v.

## Timing
- Handshake at cycle t → div_*_tvalid at t+1 → divider result at t+1+LATENCY → rsp_valid at t+2+LATENCY. Total latency LATENCY+2.
- Throughput: one request per cycle summed over all requesters. At most LATENCY+1 ops are in flight.
- Responses leave in issue order. No two responses share a cycle.
- Simultaneous requests: only one grant per cycle. A requester that loses the arbitration keeps req_valid held and is granted within N_REQ cycles.
- A single requester holding req_valid continuously is granted every cycle.
- Reset asserted mid-operation: in-flight ops are discarded with no rsp. Stale divider outputs during the flush window are ignored.

## Configuration
- DIV_ZERO_GUARD_EN defined:
  - A request with divisor 0 is accepted but not issued to the divider (div_*_tvalid stays 0 that cycle).
  - Its tag carries z=1.
  - It responds at the normal latency with rsp_data=48'hFFFF_FFFF_FFFF and rsp_div_zero=1.
- DIV_ZERO_GUARD_EN undefined: every request is issued to the divider, z is always 0, and rsp_div_zero is tied 0.

## Test plan
- Single request, N_REQ=4, LATENCY=44: requester 2 sends 40'd1000 / 8'd10 → div_a_tdata=1000 at t+1; model returns 100 at t+45 → rsp_valid=4'b0100 and rsp_data=100 at t+46, sync_err=0.
- All 4 requesters valid continuously → grants 0,1,2,3,0… on consecutive cycles; responses return in the same order, one per cycle, each to the correct index.
- Reset at cycle 10 with 8 ops in flight; model keeps emitting their results → no rsp_valid, no sync_err, req_ready=0 for 45 cycles, then the first grant.
- Model drops one result (div_result_tvalid=0 at the expected cycle) → sync_err=1 from the following cycle and stays 1 until reset; later ops respond normally.
- DIV_ZERO_GUARD_EN: requester 1 sends divisor 0 between two normal requests → no divider issue for it; rsp_data=48'hFFFF_FFFF_FFFF and rsp_div_zero=1 at its slot; neighbouring responses are correct; sync_err=0.
- Without the macro, the same stimulus → the divisor-0 request is issued to the divider, and rsp_div_zero stays 0.
